// File: rtl/even_bit_counter_pkg.sv
// Shared types for the even/odd bit counter: controller states, count-mode codes
// and the count-width helper used by the interface, datapath and top.
package even_bit_counter_pkg;

  typedef enum logic [2:0] {
    S_SOC = 3'd0,
    S_EOC = 3'd1,
    S_CNT = 3'd2,
    S_DAV = 3'd3,
    S_ACK = 3'd4
  } state_e;

  localparam logic [1:0] MODE_EVEN = 2'b00;
  localparam logic [1:0] MODE_ODD  = 2'b01;
  localparam logic [1:0] MODE_ALL  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  function automatic int calc_cw(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/even_bit_counter_if.sv
// Converter and consumer signals of the bit counter. EVEN_BIT_COUNTER_MASK_EN adds
// the per-consumer enable mask en.
interface even_bit_counter_if #(
  parameter int W = 8,
  parameter int N = 3
) ();
  import even_bit_counter_pkg::*;

  localparam int CW = calc_cw(W);

  logic          soc;
  logic          eoc;
  logic [W-1:0]  x;
  logic [1:0]    mode;
  logic [N-1:0]  rfd;
  logic          dav_;
  logic [CW-1:0] c;
`ifdef EVEN_BIT_COUNTER_MASK_EN
  logic [N-1:0]  en;

  modport master (output soc, dav_, c, input eoc, x, mode, rfd, en);
  modport slave  (input soc, dav_, c, output eoc, x, mode, rfd, en);
`else
  modport master (output soc, dav_, c, input eoc, x, mode, rfd);
  modport slave  (input soc, dav_, c, output eoc, x, mode, rfd);
`endif

endinterface

// File: rtl/ebc_datapath.sv
// Bit-counting datapath: holds the captured sample and mode, consumes two bit
// positions per step and flags when no selected bit remains.
module ebc_datapath
  import even_bit_counter_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = calc_cw(W)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [W-1:0]  x,
  input  logic [1:0]    mode,
  output logic [CW-1:0] c,
  output logic          done
);

  logic [W-1:0]  x_q, x_d;
  logic [CW-1:0] c_q, c_d;
  logic [1:0]    mode_q, mode_d;
  logic [W-1:0]  mask_s;
  logic [W-1:0]  x_shift_s;
  logic [1:0]    pair_add_s;

  // Selected-position mask, per-step increment and early-exit detect
  always_comb begin
    mask_s     = '0;
    pair_add_s = 2'd0;
    x_shift_s  = x_q >> 2;
    for (int i = 0; i < W; i++) begin
      case (mode_q)
        MODE_EVEN:           mask_s[i] = (i % 2 == 0);
        MODE_ODD:            mask_s[i] = (i % 2 == 1);
        MODE_ALL, MODE_RSVD: mask_s[i] = 1'b1;
        default:             mask_s[i] = 1'b1;
      endcase
    end
    case (mode_q)
      MODE_EVEN:           pair_add_s = {1'b0, x_q[0]};
      MODE_ODD:            pair_add_s = {1'b0, x_q[1]};
      MODE_ALL, MODE_RSVD: pair_add_s = {1'b0, x_q[0]} + {1'b0, x_q[1]};
      default:             pair_add_s = {1'b0, x_q[0]} + {1'b0, x_q[1]};
    endcase
    // Exit decision looks at what is left after this step's shift
    done = ((x_shift_s & mask_s) == '0);
  end

  // Next-state of sample, mode and accumulator
  always_comb begin
    x_d    = x_q;
    c_d    = c_q;
    mode_d = mode_q;
    if (load) begin
      x_d    = x;
      c_d    = '0;
      mode_d = mode;
    end else if (step) begin
      x_d = x_shift_s;
      c_d = c_q + CW'(pair_add_s);
    end else begin
      x_d = x_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      c_q    <= '0;
      mode_q <= MODE_EVEN;
    end else begin
      x_q    <= x_d;
      c_q    <= c_d;
      mode_q <= mode_d;
    end
  end

  assign c = c_q;

endmodule

// File: rtl/even_bit_counter_n.sv
// Converter-driven bit counter with a shared dav_/rfd handshake to N consumers.
// Optional EVEN_BIT_COUNTER_MASK_EN selects which consumers take part.
module even_bit_counter_n
  import even_bit_counter_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic clock,
  input  logic reset,
  even_bit_counter_if.master bus
);

  localparam int CW = calc_cw(W);

  state_e        state_q, state_d;
  logic          soc_q, soc_d;
  logic          dav_n_q, dav_n_d;
  logic          load_s;
  logic          step_s;
  logic          done_s;
  logic [N-1:0]  part_s;
  logic [CW-1:0] c_s;

`ifdef EVEN_BIT_COUNTER_MASK_EN
  logic [N-1:0] en_q, en_d;

  // Enable mask is captured with the sample and mode
  always_comb begin
    en_d = en_q;
    if (load_s) begin
      en_d = bus.en;
    end else begin
      en_d = en_q;
    end
  end

  // Enable mask register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q <= '0;
    end else begin
      en_q <= en_d;
    end
  end

  assign part_s = en_q;
`else
  assign part_s = {N{1'b1}};
`endif

  ebc_datapath #(
    .W  (W),
    .CW (CW)
  ) u_datapath (
    .clock (clock),
    .reset (reset),
    .load  (load_s),
    .step  (step_s),
    .x     (bus.x),
    .mode  (bus.mode),
    .c     (c_s),
    .done  (done_s)
  );

  // Controller next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    soc_d   = soc_q;
    dav_n_d = dav_n_q;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_q)
      S_SOC: begin
        // soc must be seen high before a falling eoc may start the conversion
        if (!soc_q) begin
          soc_d = 1'b1;
        end else if (!bus.eoc) begin
          soc_d   = 1'b0;
          load_s  = 1'b1;
          state_d = S_EOC;
        end else begin
          soc_d = 1'b1;
        end
      end
      S_EOC: begin
        if (bus.eoc) begin
          state_d = S_CNT;
        end else begin
          state_d = S_EOC;
        end
      end
      S_CNT: begin
        step_s = 1'b1;
        if (done_s) begin
          dav_n_d = 1'b0;
          state_d = S_DAV;
        end else begin
          state_d = S_CNT;
        end
      end
      S_DAV: begin
        if ((bus.rfd & part_s) == '0) begin
          dav_n_d = 1'b1;
          state_d = S_ACK;
        end else begin
          state_d = S_DAV;
        end
      end
      S_ACK: begin
        if ((bus.rfd & part_s) == part_s) begin
          soc_d   = 1'b1;
          state_d = S_SOC;
        end else begin
          state_d = S_ACK;
        end
      end
      default: begin
        soc_d   = 1'b0;
        dav_n_d = 1'b1;
        state_d = S_SOC;
      end
    endcase
  end

  // Controller state and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_SOC;
      soc_q   <= 1'b0;
      dav_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      soc_q   <= soc_d;
      dav_n_q <= dav_n_d;
    end
  end

  assign bus.soc  = soc_q;
  assign bus.dav_ = dav_n_q;
  assign bus.c    = c_s;

endmodule
